// File: rtl/sa_tile_scheduler.sv
// Batch sequencer for a 4x4 int8 systolic array: per tile it fetches A/B rows,
// clears and runs the array, then writes back the four C rows.
module sa_tile_scheduler #(
  parameter int ADDR_BITS  = 16,
  parameter int DATA_BITS  = 32,
  parameter int DATAC_BITS = 128,
  parameter int TIMEOUT    = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_BITS-1:0]  num_tiles,
  input  logic [ADDR_BITS-1:0]  a_base,
  input  logic [ADDR_BITS-1:0]  b_base,
  input  logic [ADDR_BITS-1:0]  c_base,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic                  rd_en,
  output logic [ADDR_BITS-1:0]  rd_addr,
  input  logic [DATA_BITS-1:0]  rd_data,
  output logic [DATA_BITS-1:0]  sa_a0,
  output logic [DATA_BITS-1:0]  sa_a1,
  output logic [DATA_BITS-1:0]  sa_a2,
  output logic [DATA_BITS-1:0]  sa_a3,
  output logic [DATA_BITS-1:0]  sa_b0,
  output logic [DATA_BITS-1:0]  sa_b1,
  output logic [DATA_BITS-1:0]  sa_b2,
  output logic [DATA_BITS-1:0]  sa_b3,
  output logic                  sa_rst_n_o,
  input  logic                  sa_done_i,
  input  logic [DATAC_BITS-1:0] sa_c0,
  input  logic [DATAC_BITS-1:0] sa_c1,
  input  logic [DATAC_BITS-1:0] sa_c2,
  input  logic [DATAC_BITS-1:0] sa_c3,
  output logic                  wr_en,
  output logic [ADDR_BITS-1:0]  wr_addr,
  output logic [DATAC_BITS-1:0] wr_data
);

  // state | meaning
  // IDLE  | waiting for start
  // FETCH | 8 reads (4 A rows, 4 B rows) plus one trailing capture cycle
  // CLEAR | 2 cycles with array held in clear
  // RUN   | array running, waiting for sa_done_i or timeout
  // WRITE | 4 result row writes
  // NEXT  | advance tile counter
  // DONE  | done pulse, busy drops on exit
  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_CLEAR, S_RUN, S_WRITE, S_NEXT, S_DONE
  } state_t;

  localparam int WW = $clog2(TIMEOUT) + 1;

  state_t                state_q;
  logic [3:0]            cnt_q;
  logic [WW-1:0]         wcnt_q;
  logic [ADDR_BITS-1:0]  tile_q, off_q, num_q, abase_q, bbase_q, cbase_q;
  logic [DATA_BITS-1:0]  a_q [4];
  logic [DATA_BITS-1:0]  b_q [4];
  logic [DATAC_BITS-1:0] c_q [4];
  logic                  busy_q, done_q, err_q, rd_en_q, sa_rst_n_q, wr_en_q;
  logic [ADDR_BITS-1:0]  rd_addr_q, wr_addr_q;
  logic [DATAC_BITS-1:0] wr_data_q;

  logic [3:0]            nidx_d;
  logic [3:0]            cidx_d;
  logic [ADDR_BITS-1:0]  fetch_addr_d;
  logic [1:0]            wnext_d;

  // Address of the read issued next cycle; off_q holds 4*t.
  assign nidx_d       = cnt_q + 4'd1;
  assign cidx_d       = cnt_q - 4'd1;
  assign fetch_addr_d = (nidx_d < 4'd4) ? abase_q + off_q + ADDR_BITS'(nidx_d[1:0])
                                        : bbase_q + off_q + ADDR_BITS'(nidx_d[1:0]);
  assign wnext_d      = cnt_q[1:0] + 2'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      wcnt_q     <= '0;
      tile_q     <= '0;
      off_q      <= '0;
      num_q      <= '0;
      abase_q    <= '0;
      bbase_q    <= '0;
      cbase_q    <= '0;
      for (int i = 0; i < 4; i++) begin
        a_q[i] <= '0;
        b_q[i] <= '0;
        c_q[i] <= '0;
      end
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      rd_en_q    <= 1'b0;
      rd_addr_q  <= '0;
      sa_rst_n_q <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            num_q   <= num_tiles;
            abase_q <= a_base;
            bbase_q <= b_base;
            cbase_q <= c_base;
            err_q   <= 1'b0;
            busy_q  <= 1'b1;
            tile_q  <= '0;
            off_q   <= '0;
            cnt_q   <= '0;
            if (num_tiles == '0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q   <= S_FETCH;
              rd_en_q   <= 1'b1;
              rd_addr_q <= a_base;
            end
          end
        end

        S_FETCH: begin
          // Data for read cnt-1 arrives this cycle.
          if (cnt_q != 4'd0) begin
            if (cidx_d < 4'd4) a_q[cidx_d[1:0]] <= rd_data;
            else               b_q[cidx_d[1:0]] <= rd_data;
          end
          if (cnt_q < 4'd7) begin
            rd_en_q   <= 1'b1;
            rd_addr_q <= fetch_addr_d;
          end else begin
            rd_en_q <= 1'b0;
          end
          if (cnt_q == 4'd8) begin
            state_q <= S_CLEAR;
            cnt_q   <= '0;
          end else begin
            cnt_q <= nidx_d;
          end
        end

        S_CLEAR: begin
          if (cnt_q == 4'd1) begin
            state_q    <= S_RUN;
            sa_rst_n_q <= 1'b1;
            wcnt_q     <= '0;
          end else begin
            cnt_q <= nidx_d;
          end
        end

        S_RUN: begin
          if (sa_done_i) begin
            c_q[0]     <= sa_c0;
            c_q[1]     <= sa_c1;
            c_q[2]     <= sa_c2;
            c_q[3]     <= sa_c3;
            sa_rst_n_q <= 1'b0;
            state_q    <= S_WRITE;
            cnt_q      <= '0;
            wr_en_q    <= 1'b1;
            wr_addr_q  <= cbase_q + off_q;
            wr_data_q  <= sa_c0;
          end else if (wcnt_q == WW'(TIMEOUT - 1)) begin
            err_q      <= 1'b1;
            sa_rst_n_q <= 1'b0;
            state_q    <= S_DONE;
            done_q     <= 1'b1;
          end else begin
            wcnt_q <= wcnt_q + WW'(1);
          end
        end

        S_WRITE: begin
          if (cnt_q == 4'd3) begin
            wr_en_q <= 1'b0;
            state_q <= S_NEXT;
          end else begin
            wr_addr_q <= cbase_q + off_q + ADDR_BITS'(wnext_d);
            wr_data_q <= c_q[wnext_d];
            cnt_q     <= nidx_d;
          end
        end

        S_NEXT: begin
          tile_q <= tile_q + ADDR_BITS'(1);
          off_q  <= off_q + ADDR_BITS'(4);
          if (tile_q + ADDR_BITS'(1) == num_q) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end else begin
            state_q   <= S_FETCH;
            cnt_q     <= '0;
            rd_en_q   <= 1'b1;
            rd_addr_q <= abase_q + off_q + ADDR_BITS'(4);
          end
        end

        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign err_o      = err_q;
  assign rd_en      = rd_en_q;
  assign rd_addr    = rd_addr_q;
  assign sa_rst_n_o = sa_rst_n_q;
  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign sa_a0 = a_q[0];
  assign sa_a1 = a_q[1];
  assign sa_a2 = a_q[2];
  assign sa_a3 = a_q[3];
  assign sa_b0 = b_q[0];
  assign sa_b1 = b_q[1];
  assign sa_b2 = b_q[2];
  assign sa_b3 = b_q[3];

endmodule

// File: tb/tb_sa_tile_scheduler.sv
// Bench for sa_tile_scheduler: operand memory, 4x4 int8 array model and a
// transaction-level reference of the expected read/write traffic per batch.
module tb_sa_tile_scheduler;
  localparam int TO = 64;
  localparam int RUN_LAT = 13;

  logic         clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [15:0]  num_tiles = '0, a_base = '0, b_base = '0, c_base = '0;
  logic         busy_o, done_o, err_o, rd_en, sa_rst_n_o, wr_en;
  logic [15:0]  rd_addr, wr_addr;
  logic [31:0]  rd_data = '0;
  logic [31:0]  sa_a0, sa_a1, sa_a2, sa_a3, sa_b0, sa_b1, sa_b2, sa_b3;
  logic         sa_done_i = 1'b0;
  logic [127:0] sa_c0 = '0, sa_c1 = '0, sa_c2 = '0, sa_c3 = '0;
  logic [127:0] wr_data;

  sa_tile_scheduler #(.ADDR_BITS(16), .DATA_BITS(32), .DATAC_BITS(128), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .num_tiles(num_tiles),
    .a_base(a_base), .b_base(b_base), .c_base(c_base),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .sa_a0(sa_a0), .sa_a1(sa_a1), .sa_a2(sa_a2), .sa_a3(sa_a3),
    .sa_b0(sa_b0), .sa_b1(sa_b1), .sa_b2(sa_b2), .sa_b3(sa_b3),
    .sa_rst_n_o(sa_rst_n_o), .sa_done_i(sa_done_i),
    .sa_c0(sa_c0), .sa_c1(sa_c1), .sa_c2(sa_c2), .sa_c3(sa_c3),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:65535];
  int n_cmp = 0, n_err = 0;
  bit hang = 1'b0;
  int run_cnt = 0;
  int done_cnt = 0, busy_cyc = 0, run_cyc = 0;
  logic [15:0]  obs_rd[$], obs_wa[$], exp_rd[$], exp_wa[$];
  logic [127:0] obs_wd[$], exp_wd[$];
  int exp_busy, exp_run;
  bit exp_err;

  // One C row: row of A times the 4x4 B matrix, int8 signed, byte 3 = column 0.
  function automatic logic [127:0] mm_row(logic [31:0] ar, logic [31:0] b0, logic [31:0] b1,
                                          logic [31:0] b2, logic [31:0] b3);
    logic [31:0] br [4];
    logic signed [31:0] acc, x, y;
    logic [127:0] r;
    br[0] = b0; br[1] = b1; br[2] = b2; br[3] = b3;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      acc = 0;
      for (int k = 0; k < 4; k++) begin
        x = $signed(ar[31-8*k -: 8]);
        y = $signed(br[k][31-8*c -: 8]);
        acc = acc + x * y;
      end
      r[127-32*c -: 32] = acc;
    end
    return r;
  endfunction

  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  always @(posedge clk) begin
    if (sa_rst_n_o && !hang) begin
      run_cnt = run_cnt + 1;
      if (run_cnt == RUN_LAT - 1) begin
        sa_done_i <= 1'b1;
        sa_c0 <= mm_row(sa_a0, sa_b0, sa_b1, sa_b2, sa_b3);
        sa_c1 <= mm_row(sa_a1, sa_b0, sa_b1, sa_b2, sa_b3);
        sa_c2 <= mm_row(sa_a2, sa_b0, sa_b1, sa_b2, sa_b3);
        sa_c3 <= mm_row(sa_a3, sa_b0, sa_b1, sa_b2, sa_b3);
      end else begin
        sa_done_i <= 1'b0;
      end
    end else begin
      run_cnt = 0;
      sa_done_i <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (rd_en) obs_rd.push_back(rd_addr);
    if (wr_en) begin
      obs_wa.push_back(wr_addr);
      obs_wd.push_back(wr_data);
    end
    if (done_o) done_cnt++;
    if (busy_o) busy_cyc++;
    if (sa_rst_n_o) run_cyc++;
  end

  task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic prep(int n, logic [15:0] ab, logic [15:0] bb, logic [15:0] cb, bit hg);
    int tiles_rd;
    logic [15:0] ra;
    #1;
    exp_rd.delete(); exp_wa.delete(); exp_wd.delete();
    obs_rd.delete(); obs_wa.delete(); obs_wd.delete();
    done_cnt = 0; busy_cyc = 0; run_cyc = 0;
    hang = hg;
    exp_err = hg && (n > 0);
    tiles_rd = hg ? ((n > 0) ? 1 : 0) : n;
    for (int t = 0; t < tiles_rd; t++) begin
      for (int i = 0; i < 4; i++) begin ra = ab + 16'(4*t + i); exp_rd.push_back(ra); end
      for (int i = 0; i < 4; i++) begin ra = bb + 16'(4*t + i); exp_rd.push_back(ra); end
    end
    if (!hg) begin
      for (int t = 0; t < n; t++) begin
        for (int j = 0; j < 4; j++) begin
          ra = cb + 16'(4*t + j);
          exp_wa.push_back(ra);
          exp_wd.push_back(mm_row(mem[ab + 16'(4*t + j)],
                                  mem[bb + 16'(4*t)],     mem[bb + 16'(4*t + 1)],
                                  mem[bb + 16'(4*t + 2)], mem[bb + 16'(4*t + 3)]));
        end
      end
    end
    // busy covers each tile (9 fetch + 2 clear + run + 4 write + 1 next) plus DONE.
    if (n == 0)  begin exp_busy = 1;              exp_run = 0;  end
    else if (hg) begin exp_busy = 9 + 2 + TO + 1; exp_run = TO; end
    else         begin exp_busy = n * (9 + 2 + RUN_LAT + 4 + 1) + 1; exp_run = n * RUN_LAT; end
  endtask

  task automatic launch(int n, logic [15:0] ab, logic [15:0] bb, logic [15:0] cb);
    @(negedge clk);
    num_tiles = 16'(n); a_base = ab; b_base = bb; c_base = cb; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    num_tiles = 16'($urandom); a_base = 16'($urandom); b_base = 16'($urandom); c_base = 16'($urandom);
  endtask

  task automatic finish_check(string tag);
    int cyc = 0;
    while (done_cnt == 0 && cyc < 3000) begin
      @(negedge clk); #1; cyc++;
    end
    repeat (4) @(negedge clk);
    #1;
    chk({tag, " done_cnt"}, done_cnt, 1);
    chk({tag, " err"}, err_o, exp_err);
    chk({tag, " busy_cycles"}, busy_cyc, exp_busy);
    chk({tag, " run_cycles"}, run_cyc, exp_run);
    chk({tag, " n_reads"}, obs_rd.size(), exp_rd.size());
    for (int i = 0; i < exp_rd.size(); i++)
      chk($sformatf("%s rd_addr[%0d]", tag, i), (i < obs_rd.size()) ? obs_rd[i] : 16'hxxxx, exp_rd[i]);
    chk({tag, " n_writes"}, obs_wa.size(), exp_wa.size());
    for (int i = 0; i < exp_wa.size(); i++) begin
      chk($sformatf("%s wr_addr[%0d]", tag, i), (i < obs_wa.size()) ? obs_wa[i] : 16'hxxxx, exp_wa[i]);
      chk($sformatf("%s wr_data[%0d]", tag, i), (i < obs_wd.size()) ? obs_wd[i] : 128'hx, exp_wd[i]);
    end
  endtask

  task automatic chk_all_zero(string tag);
    chk({tag, " ctrl"}, {busy_o, done_o, err_o, rd_en, wr_en, sa_rst_n_o, rd_addr, wr_addr}, '0);
    chk({tag, " wr_data"}, wr_data, '0);
    chk({tag, " sa_a"}, {sa_a0, sa_a1, sa_a2, sa_a3}, '0);
    chk({tag, " sa_b"}, {sa_b0, sa_b1, sa_b2, sa_b3}, '0);
  endtask

  initial begin
    logic [15:0] ab, bb, cb;
    int n, cyc, wc;
    for (int i = 0; i < 65536; i++) mem[i] = $urandom;

    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;

    // T1: identity A times B holding bytes 1..16
    for (int i = 0; i < 4; i++) begin
      mem[i]     = 32'h01 << (8 * (3 - i));
      mem[4 + i] = {8'(4*i + 1), 8'(4*i + 2), 8'(4*i + 3), 8'(4*i + 4)};
    end
    prep(1, 16'h0000, 16'h0004, 16'h0020, 1'b0);
    launch(1, 16'h0000, 16'h0004, 16'h0020);
    chk("T1 busy after start", busy_o, 1'b1);
    finish_check("T1");
    chk("T1 row0 literal", (obs_wd.size() > 0) ? obs_wd[0] : 128'hx,
        128'h00000001_00000002_00000003_00000004);
    chk("T1 busy idle", busy_o, 1'b0);

    // T2: three tiles at fixed bases
    prep(3, 16'h0010, 16'h0040, 16'h0080, 1'b0);
    launch(3, 16'h0010, 16'h0040, 16'h0080);
    finish_check("T2");

    // T3: empty batch
    prep(0, 16'h1234, 16'h2345, 16'h3456, 1'b0);
    launch(0, 16'h1234, 16'h2345, 16'h3456);
    chk("T3 done next cycle", done_o, 1'b1);
    finish_check("T3");

    // T4: array never finishes
    prep(2, 16'h0100, 16'h0200, 16'h0300, 1'b1);
    launch(2, 16'h0100, 16'h0200, 16'h0300);
    finish_check("T4");
    chk("T4 err sticky", err_o, 1'b1);

    // T5: start during RUN of tile 0 is ignored; also clears err from T4
    ab = 16'($urandom); bb = 16'($urandom); cb = 16'($urandom);
    prep(2, ab, bb, cb, 1'b0);
    launch(2, ab, bb, cb);
    chk("T5 err cleared", err_o, 1'b0);
    cyc = 0;
    while (!sa_rst_n_o && cyc < 200) begin @(negedge clk); cyc++; end
    chk("T5 reached run", sa_rst_n_o, 1'b1);
    num_tiles = 16'd5; a_base = ab + 16'h0100; b_base = bb + 16'h0100; c_base = cb + 16'h0100;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    finish_check("T5");

    // T6: reset during the second WRITE cycle
    prep(1, 16'h0500, 16'h0600, 16'h0700, 1'b0);
    launch(1, 16'h0500, 16'h0600, 16'h0700);
    wc = 0; cyc = 0;
    while (wc < 2 && cyc < 300) begin
      @(negedge clk); cyc++;
      if (wr_en) wc++;
    end
    chk("T6 reached write", wc, 2);
    rst = 1'b1;
    @(negedge clk);
    chk_all_zero("T6 after rst");
    rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("T6 writes before rst", obs_wa.size(), 2);
    chk("T6 no done", done_cnt, 0);
    ab = 16'($urandom); bb = 16'($urandom); cb = 16'($urandom);
    prep(1, ab, bb, cb, 1'b0);
    launch(1, ab, bb, cb);
    finish_check("T6 clean");

    // Random batches, one straddling the address wrap
    for (int r = 0; r < 3; r++) begin
      n  = $urandom_range(1, 3);
      ab = (r == 0) ? 16'hFFFE : 16'($urandom);
      bb = (r == 0) ? 16'hFFF9 : 16'($urandom);
      cb = (r == 0) ? 16'hFFFC : 16'($urandom);
      prep(n, ab, bb, cb, 1'b0);
      launch(n, ab, bb, cb);
      finish_check($sformatf("rand%0d", r));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
